// File: rtl/stack_ctrl_pkg.sv
// Shared types for the stack controller: FSM states, debug opcodes, stack2 delta codes.
package stack_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DBG_PEEK  = 2'b00,
        DBG_PUSH  = 2'b01,
        DBG_WRITE = 2'b10,
        DBG_POP   = 2'b11
    } dbg_op_t;

    localparam logic [1:0] DELTA_NONE = 2'b00;
    localparam logic [1:0] DELTA_PUSH = 2'b01;
    localparam logic [1:0] DELTA_BAD  = 2'b10;
    localparam logic [1:0] DELTA_POP  = 2'b11;

endpackage

// File: rtl/stack_depth_tracker.sv
// Mirrors the stack2 occupancy from the issued delta, saturating at 0 and DEPTH,
// and keeps the sticky overflow/underflow/illegal-delta flags.
module stack_depth_tracker
    import stack_ctrl_pkg::*;
#(
    parameter int DEPTH = 18
) (
    input  logic       clk,
    input  logic       resetq,
    input  logic [1:0] delta,
    input  logic       bad_set,
    input  logic       clr_flags,
    output logic [4:0] depth,
    output logic       full,
    output logic       empty,
    output logic       ovf,
    output logic       unf,
    output logic       bad_delta
);

    localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

    logic push;
    logic pop;
    logic ovf_set;
    logic unf_set;

    assign push    = (delta == DELTA_PUSH);
    assign pop     = (delta == DELTA_POP);
    assign full    = (depth == DEPTH_MAX);
    assign empty   = (depth == 5'd0);
    // Only the CPU can issue a push at full or a pop at empty; debug blocks them upstream.
    assign ovf_set = push && full;
    assign unf_set = pop && empty;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            depth     <= 5'd0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            bad_delta <= 1'b0;
        end else begin
            if (push && !full) begin
                depth <= depth + 5'd1;
            end else if (pop && !empty) begin
                depth <= depth - 5'd1;
            end
            ovf       <= ovf_set | (ovf & ~clr_flags);
            unf       <= unf_set | (unf & ~clr_flags);
            bad_delta <= bad_set | (bad_delta & ~clr_flags);
        end
    end

endmodule

// File: rtl/stack_ctrl.sv
// Arbitrates stack2 between the CPU and a halt-mode debug port, with one-cycle
// debug responses and occupancy/error status.
module stack_ctrl
    import stack_ctrl_pkg::*;
#(
    parameter int DEPTH = 18
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_delta,
    input  logic [31:0] cpu_wd,
    output logic [31:0] cpu_rd,
    input  logic        cpu_halt,
    input  logic        dbg_valid,
    output logic        dbg_ready,
    input  logic [1:0]  dbg_op,
    input  logic [31:0] dbg_wd,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_err,
    output logic        stk_we,
    output logic [1:0]  stk_delta,
    output logic [31:0] stk_wd,
    input  logic [31:0] stk_rd,
    output logic [4:0]  depth,
    output logic        ovf,
    output logic        unf,
    output logic        bad_delta,
    output logic        halted,
    input  logic        clr_flags
);

    state_t  state;
    state_t  state_nxt;
    dbg_op_t op;
    logic    accept;
    logic    blocked;
    logic    bad_set;
    logic    full;
    logic    empty;
    logic    err_q;

    assign op        = dbg_op_t'(dbg_op);
    assign dbg_ready = (state == ST_HALT);
    assign accept    = dbg_valid && dbg_ready;
    assign blocked   = ((op == DBG_PUSH) && full) || ((op == DBG_POP) && empty);
    assign halted    = (state != ST_RUN);
    assign cpu_rd    = stk_rd;
    // stack2 is write-first, so the response cycle already sees the post-command TOS.
    assign dbg_rvalid = (state == ST_RESP);
    assign dbg_rdata  = dbg_rvalid ? stk_rd : 32'd0;
    assign dbg_err    = dbg_rvalid && err_q;

    always_comb begin
        state_nxt = state;
        stk_we    = 1'b0;
        stk_delta = DELTA_NONE;
        stk_wd    = cpu_wd;
        bad_set   = 1'b0;
        case (state)
            ST_RUN: begin
                if (cpu_delta == DELTA_BAD) begin
                    bad_set = 1'b1;
                end else begin
                    stk_we    = cpu_we;
                    stk_delta = cpu_delta;
                end
                if (cpu_halt) state_nxt = ST_HALT;
            end
            ST_HALT: begin
                stk_wd = dbg_wd;
                if (accept) begin
                    state_nxt = ST_RESP;
                    if (!blocked) begin
                        case (op)
                            DBG_PEEK:  stk_delta = DELTA_NONE;
                            DBG_PUSH:  begin stk_we = 1'b1; stk_delta = DELTA_PUSH; end
                            DBG_WRITE: stk_we = 1'b1;
                            DBG_POP:   stk_delta = DELTA_POP;
                            default:   stk_delta = DELTA_NONE;
                        endcase
                    end
                end else if (!cpu_halt) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RESP: state_nxt = cpu_halt ? ST_HALT : ST_RUN;
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state <= ST_RUN;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) err_q <= blocked;
        end
    end

    stack_depth_tracker #(
        .DEPTH(DEPTH)
    ) u_depth (
        .clk       (clk),
        .resetq    (resetq),
        .delta     (stk_delta),
        .bad_set   (bad_set),
        .clr_flags (clr_flags),
        .depth     (depth),
        .full      (full),
        .empty     (empty),
        .ovf       (ovf),
        .unf       (unf),
        .bad_delta (bad_delta)
    );

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: a stack2 stand-in plus a queue-based reference of stack
// contents, occupancy, flags and debug handshake; directed scenarios then random traffic.
module tb_stack_ctrl;

    localparam int DEPTH = 18;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_delta = 2'b00;
    logic [31:0] cpu_wd = 32'd0;
    logic [31:0] cpu_rd;
    logic        cpu_halt = 1'b0;
    logic        dbg_valid = 1'b0;
    logic        dbg_ready;
    logic [1:0]  dbg_op = 2'b00;
    logic [31:0] dbg_wd = 32'd0;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        dbg_err;
    logic        stk_we;
    logic [1:0]  stk_delta;
    logic [31:0] stk_wd;
    logic [31:0] stk_rd;
    logic [4:0]  depth;
    logic        ovf, unf, bad_delta, halted;
    logic        clr_flags = 1'b0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    stack_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .resetq(resetq),
        .cpu_we(cpu_we), .cpu_delta(cpu_delta), .cpu_wd(cpu_wd), .cpu_rd(cpu_rd),
        .cpu_halt(cpu_halt),
        .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_op(dbg_op), .dbg_wd(dbg_wd),
        .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .dbg_err(dbg_err),
        .stk_we(stk_we), .stk_delta(stk_delta), .stk_wd(stk_wd), .stk_rd(stk_rd),
        .depth(depth), .ovf(ovf), .unf(unf), .bad_delta(bad_delta), .halted(halted),
        .clr_flags(clr_flags)
    );

    // stack2 stand-in: circular pointer of DEPTH entries, write-first, never reset.
    logic [31:0] mem [0:31];
    logic [4:0]  sp = 5'd0;
    logic [4:0]  nsp;
    assign stk_rd = mem[sp];

    initial for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    always @(posedge clk) begin
        nsp = sp;
        if (stk_delta == 2'b01) nsp = (sp == 5'(DEPTH - 1)) ? 5'd0 : sp + 5'd1;
        else if (stk_delta == 2'b11) nsp = (sp == 5'd0) ? 5'(DEPTH - 1) : sp - 5'd1;
        if (stk_we) mem[nsp] <= stk_wd;
        sp <= nsp;
    end

    // Reference state
    bit          halted_m, resp_m, err_m, ovf_m, unf_m, bad_m, q_ok;
    int          depth_m;
    logic [31:0] q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        halted_m = 0; resp_m = 0; err_m = 0;
        ovf_m = 0; unf_m = 0; bad_m = 0;
        depth_m = 0; q.delete(); q_ok = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        cpu_we = 0; cpu_delta = 2'b00; cpu_halt = 0; dbg_valid = 0; clr_flags = 0;
        resetq = 1'b0;
        #1;
        check_val("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check_val("rst_rdata", dbg_rdata, 32'd0);
        check_val("rst_err", 32'(dbg_err), 32'd0);
        check_val("rst_depth", 32'(depth), 32'd0);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_flags", {29'd0, ovf, unf, bad_delta}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        resetq = 1'b1;
        model_reset();
    endtask

    task automatic step(input logic we, input logic [1:0] dl, input logic [31:0] wd,
                        input logic hlt, input logic dv, input logic [1:0] op,
                        input logic [31:0] dw, input logic clr);
        bit          blocked, s_ovf, s_unf, s_bad;
        logic        ewe;
        logic [1:0]  edl;
        logic [31:0] ewd;
        @(negedge clk);
        cpu_we = we; cpu_delta = dl; cpu_wd = wd; cpu_halt = hlt;
        dbg_valid = dv; dbg_op = op; dbg_wd = dw; clr_flags = clr;
        #1;
        ewe = 0; edl = 2'b00; ewd = 32'd0; blocked = 0;
        if (!halted_m) begin
            if (dl != 2'b10) begin ewe = we; edl = dl; ewd = wd; end
        end else if (!resp_m && dv) begin
            blocked = (op == 2'd1 && depth_m == DEPTH) || (op == 2'd3 && depth_m == 0);
            if (!blocked) begin
                case (op)
                    2'd1: begin ewe = 1; edl = 2'b01; ewd = dw; end
                    2'd2: begin ewe = 1; ewd = dw; end
                    2'd3: edl = 2'b11;
                    default: ;
                endcase
            end
        end
        check_val("stk_we", 32'(stk_we), 32'(ewe));
        check_val("stk_delta", 32'(stk_delta), 32'(edl));
        if (ewe) check_val("stk_wd", stk_wd, ewd);
        check_val("dbg_ready", 32'(dbg_ready), 32'(halted_m && !resp_m));
        check_val("halted", 32'(halted), 32'(halted_m));
        check_val("dbg_rvalid", 32'(dbg_rvalid), 32'(resp_m));
        check_val("dbg_err", 32'(dbg_err), 32'(resp_m && err_m));
        if (!resp_m) check_val("dbg_rdata_idle", dbg_rdata, 32'd0);
        else begin
            check_val("dbg_rdata_rd", dbg_rdata, stk_rd);
            if (q_ok && q.size() > 0) check_val("dbg_rdata_tos", dbg_rdata, q[$]);
        end
        check_val("depth", 32'(depth), 32'(depth_m));
        check_val("ovf", 32'(ovf), 32'(ovf_m));
        check_val("unf", 32'(unf), 32'(unf_m));
        check_val("bad_delta", 32'(bad_delta), 32'(bad_m));
        if (q_ok && q.size() > 0) check_val("cpu_rd", cpu_rd, q[$]);
        @(posedge clk);
        s_ovf = 0; s_unf = 0; s_bad = 0;
        if (!halted_m) begin
            if (dl == 2'b10) s_bad = 1;
            else if (dl == 2'b01) begin
                if (depth_m == DEPTH) begin s_ovf = 1; q_ok = 0; end
                else begin depth_m++; q.push_back(wd); if (!we) q_ok = 0; end
            end else if (dl == 2'b11) begin
                if (depth_m == 0) begin s_unf = 1; q_ok = 0; end
                else begin depth_m--; void'(q.pop_back()); if (we && q.size() > 0) q[$] = wd; end
            end else if (we && q.size() > 0) q[$] = wd;
            if (hlt) halted_m = 1;
        end else if (!resp_m) begin
            if (dv) begin
                resp_m = 1; err_m = blocked;
                if (!blocked) begin
                    case (op)
                        2'd1: begin depth_m++; q.push_back(dw); end
                        2'd2: if (q.size() > 0) q[$] = dw;
                        2'd3: begin depth_m--; if (q.size() > 0) void'(q.pop_back()); end
                        default: ;
                    endcase
                end
            end else if (!hlt) halted_m = 0;
        end else begin
            resp_m = 0; halted_m = hlt;
        end
        ovf_m = s_ovf | (ovf_m & !clr);
        unf_m = s_unf | (unf_m & !clr);
        bad_m = s_bad | (bad_m & !clr);
    endtask

    task automatic idle(input logic hlt);
        step(0, 2'b00, 32'd0, hlt, 0, 2'b00, 32'd0, 0);
    endtask

    initial begin
        bit          halt_lvl;
        int          r;
        logic [1:0]  dl;
        model_reset();
        do_reset();

        // CPU push A, push B, pop
        step(1, 2'b01, 32'hA, 0, 0, 2'b00, 0, 0);
        step(1, 2'b01, 32'hB, 0, 0, 2'b00, 0, 0);
        #1 check_val("s1_depth2", 32'(depth), 32'd2);
        step(0, 2'b11, 32'd0, 0, 0, 2'b00, 0, 0);
        #1 check_val("s1_depth1", 32'(depth), 32'd1);
        check_val("s1_cpu_rd", cpu_rd, 32'hA);
        idle(0);

        // Saturating push run and flag clear
        for (int i = 0; i < 19; i++) step(1, 2'b01, 32'(100 + i), 0, 0, 2'b00, 0, 0);
        #1 check_val("s2_depth", 32'(depth), 32'd18);
        check_val("s2_ovf", 32'(ovf), 32'd1);
        step(0, 2'b00, 0, 0, 0, 2'b00, 0, 1);
        #1 check_val("s2_ovf_clr", 32'(ovf), 32'd0);
        do_reset();

        // Illegal delta
        step(1, 2'b10, 32'h77, 0, 0, 2'b00, 0, 0);
        #1 check_val("s3_bad", 32'(bad_delta), 32'd1);
        check_val("s3_depth", 32'(depth), 32'd0);

        // Debug push then peek
        idle(1);
        step(0, 2'b00, 0, 1, 1, 2'b01, 32'h1234, 0);
        #1 check_val("s4_push_rvalid", 32'(dbg_rvalid), 32'd1);
        check_val("s4_push_rdata", dbg_rdata, 32'h1234);
        check_val("s4_depth", 32'(depth), 32'd1);
        idle(1);
        step(0, 2'b00, 0, 1, 1, 2'b00, 32'd0, 0);
        #1 check_val("s4_peek_rdata", dbg_rdata, 32'h1234);
        check_val("s4_peek_err", 32'(dbg_err), 32'd0);
        idle(1);

        // Debug pop down to empty, then a blocked pop
        step(0, 2'b00, 0, 1, 1, 2'b11, 0, 0);
        idle(1);
        step(0, 2'b00, 0, 1, 1, 2'b11, 0, 0);
        #1 check_val("s5_err", 32'(dbg_err), 32'd1);
        check_val("s5_unf", 32'(unf), 32'd0);
        check_val("s5_depth", 32'(depth), 32'd0);
        idle(1);

        // Halt dropped on the accept cycle: response still completes
        step(0, 2'b00, 0, 0, 1, 2'b00, 0, 0);
        #1 check_val("s6_rvalid", 32'(dbg_rvalid), 32'd1);
        idle(0);
        #1 check_val("s6_run", 32'(halted), 32'd0);

        // Reset while a response is pending
        idle(1);
        step(0, 2'b00, 0, 1, 1, 2'b01, 32'h55, 0);
        do_reset();
        idle(0);

        // Randomized traffic with periodic resets
        halt_lvl = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 400 == 399) do_reset();
            if ($urandom_range(0, 19) == 0) halt_lvl = !halt_lvl;
            r = $urandom_range(0, 15);
            if (r < 6) dl = 2'b01;
            else if (r < 11) dl = 2'b11;
            else if (r < 15) dl = 2'b00;
            else dl = 2'b10;
            if (dl == 2'b11 && depth_m == 0 && $urandom_range(0, 7) != 0) dl = 2'b01;
            if (dl == 2'b01 && depth_m == DEPTH && $urandom_range(0, 7) != 0) dl = 2'b11;
            step((dl == 2'b01) ? 1'b1 : 1'($urandom_range(0, 1)), dl, $urandom,
                 halt_lvl, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
                 ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
